// File: rtl/mem_arbiter_if.sv
// Request/return bus shared by icache, dcache and memory around mem_arbiter.
// slave is the arbiter's view; master is the view of everything driving it.
interface mem_arbiter_if;
  logic        ic_req_valid;
  logic [31:0] ic_req_addr;
  logic        ic_req_accepted;
  logic [1:0]  dc_req_cmd;
  logic [31:0] dc_req_addr;
  logic [63:0] dc_req_data;
  logic        dc_req_accepted;
  logic [3:0]  req_tag;
  logic [1:0]  mem_cmd;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [3:0]  mem_resp_tag;
  logic [63:0] mem_data;
  logic [3:0]  mem_data_tag;
  logic        ic_data_valid;
  logic        dc_data_valid;
  logic [63:0] ic_data;
  logic [63:0] dc_data;
  logic [3:0]  ic_data_tag;
  logic [3:0]  dc_data_tag;

  // Handshake: a request is taken in the cycle it is granted and memory answers
  // with a nonzero mem_resp_tag; the *_accepted output is that cycle's
  // acknowledgement. A tag-0 answer means retry, there is no backpressure state.
  modport slave (
    input  ic_req_valid, ic_req_addr, dc_req_cmd, dc_req_addr, dc_req_data,
    input  mem_resp_tag, mem_data, mem_data_tag,
    output ic_req_accepted, dc_req_accepted, req_tag,
    output mem_cmd, mem_addr, mem_wdata,
    output ic_data_valid, dc_data_valid, ic_data, dc_data, ic_data_tag, dc_data_tag
  );

  modport master (
    output ic_req_valid, ic_req_addr, dc_req_cmd, dc_req_addr, dc_req_data,
    output mem_resp_tag, mem_data, mem_data_tag,
    input  ic_req_accepted, dc_req_accepted, req_tag,
    input  mem_cmd, mem_addr, mem_wdata,
    input  ic_data_valid, dc_data_valid, ic_data, dc_data, ic_data_tag, dc_data_tag
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-cycle icache/dcache arbiter onto one tagged memory port, with an
// owner table that routes returning blocks back to the requester that loaded them.
module mem_arbiter #(
  parameter int NUM_TAGS     = 15,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);
  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;
  localparam int TAG_W = 4;
  localparam int TBL   = 1 << TAG_W;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [TAG_W-1:0] TAG_MAX = TAG_W'(NUM_TAGS);

  logic [CNT_W-1:0] starve_q, starve_d;
  logic [TBL-1:0]   own_vld_q, own_vld_d;
  logic [TBL-1:0]   own_dc_q, own_dc_d;

  logic dc_req, ic_force, ic_grant, dc_grant;
  logic ic_acc, dc_acc, load_acc, ret_hit;

  // Address bits below the 8-byte block are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.ic_req_addr[2:0], bus.dc_req_addr[2:0]};

  always_comb begin
    dc_req   = (bus.dc_req_cmd == CMD_LOAD) || (bus.dc_req_cmd == CMD_STORE);
    ic_force = bus.ic_req_valid && (starve_q == CNT_MAX);
    dc_grant = !reset && dc_req && !ic_force;
    ic_grant = !reset && bus.ic_req_valid && !dc_grant;
    ic_acc   = ic_grant && (bus.mem_resp_tag != '0);
    dc_acc   = dc_grant && (bus.mem_resp_tag != '0);
    load_acc = (ic_acc || (dc_acc && bus.dc_req_cmd == CMD_LOAD))
               && (bus.mem_resp_tag <= TAG_MAX);
    ret_hit  = !reset && (bus.mem_data_tag != '0) && own_vld_q[bus.mem_data_tag];
  end

  always_comb begin
    bus.mem_cmd   = CMD_NONE;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (ic_grant) begin
      bus.mem_cmd  = CMD_LOAD;
      bus.mem_addr = {bus.ic_req_addr[31:3], 3'b000};
    end else if (dc_grant) begin
      bus.mem_cmd   = bus.dc_req_cmd;
      bus.mem_addr  = {bus.dc_req_addr[31:3], 3'b000};
      bus.mem_wdata = bus.dc_req_data;
    end
    bus.ic_req_accepted = ic_acc;
    bus.dc_req_accepted = dc_acc;
    bus.req_tag         = reset ? '0 : bus.mem_resp_tag;
    bus.ic_data_valid   = ret_hit && !own_dc_q[bus.mem_data_tag];
    bus.dc_data_valid   = ret_hit &&  own_dc_q[bus.mem_data_tag];
    bus.ic_data         = reset ? '0 : bus.mem_data;
    bus.dc_data         = reset ? '0 : bus.mem_data;
    bus.ic_data_tag     = bus.ic_data_valid ? bus.mem_data_tag : '0;
    bus.dc_data_tag     = bus.dc_data_valid ? bus.mem_data_tag : '0;
  end

  // Return clears before the new assignment so a same-cycle reuse of a tag keeps the new owner.
  always_comb begin
    own_vld_d = own_vld_q;
    own_dc_d  = own_dc_q;
    if (ret_hit) own_vld_d[bus.mem_data_tag] = 1'b0;
    if (load_acc) begin
      own_vld_d[bus.mem_resp_tag] = 1'b1;
      own_dc_d[bus.mem_resp_tag]  = dc_acc;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (ic_acc)
      starve_d = '0;
    else if (bus.ic_req_valid && dc_grant && (starve_q != CNT_MAX))
      starve_d = starve_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q  <= '0;
      own_vld_q <= '0;
      own_dc_q  <= '0;
    end else begin
      starve_q  <= starve_d;
      own_vld_q <= own_vld_d;
      own_dc_q  <= own_dc_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, starvation sequences and
// random traffic, all scored against a tag-ownership reference model.
module tb_mem_arbiter;
  localparam int LIMIT = 4;
  localparam int OW    = 242;

  logic clock;
  logic reset;
  mem_arbiter_if bus ();

  mem_arbiter #(.NUM_TAGS(15), .STARVE_LIMIT(LIMIT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        rst;
    logic        icv;
    logic [31:0] ica;
    logic [1:0]  cmd;
    logic [31:0] dca;
    logic [63:0] dcd;
    logic [3:0]  rtag;
    logic [3:0]  dtag;
    logic [63:0] mdata;
    logic        e_ica;
    logic        e_dca;
    logic [1:0]  e_cmd;
    logic [31:0] e_addr;
    logic        e_icdv;
    logic        e_dcdv;
  } vec_t;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [OW-1:0] exp_q[$];

  // reference model state: starvation count and owner per outstanding load tag (0 ic, 1 dc)
  int starve_m = 0;
  int owner_m[int];

  function automatic vec_t mk(input logic rst, input logic icv, input logic [31:0] ica,
                              input logic [1:0] cmd, input logic [31:0] dca,
                              input logic [3:0] rtag, input logic [3:0] dtag,
                              input logic e_ica, input logic e_dca, input logic [1:0] e_cmd,
                              input logic [31:0] e_addr, input logic e_icdv, input logic e_dcdv);
    vec_t v;
    v.rst = rst; v.icv = icv; v.ica = ica; v.cmd = cmd; v.dca = dca;
    v.dcd = {dca, ~dca}; v.rtag = rtag; v.dtag = dtag;
    v.mdata = {32'hDA7A_0000 | 32'(dtag), ica ^ dca};
    v.e_ica = e_ica; v.e_dca = e_dca; v.e_cmd = e_cmd; v.e_addr = e_addr;
    v.e_icdv = e_icdv; v.e_dcdv = e_dcdv;
    return v;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // scoreboard: model prediction for the current cycle
  task automatic model_predict(input vec_t v);
    logic [OW-1:0] e;
    logic dcr, ic_wins, dc_wins, acc, hit;
    logic [1:0] cmd; logic [31:0] addr; logic [63:0] wdata;
    logic icdv, dcdv;
    e = '0;
    if (!v.rst) begin
      dcr     = (v.cmd == 2'd1) || (v.cmd == 2'd2);
      ic_wins = v.icv && (starve_m == LIMIT || !dcr);
      dc_wins = dcr && !ic_wins;
      cmd = 2'd0; addr = 32'd0; wdata = 64'd0;
      if (ic_wins) begin
        cmd = 2'd1; addr = v.ica & ~32'd7;
      end else if (dc_wins) begin
        cmd = v.cmd; addr = v.dca & ~32'd7; wdata = v.dcd;
      end
      acc  = (ic_wins || dc_wins) && (v.rtag != 0);
      hit  = (v.dtag != 0) && owner_m.exists(int'(v.dtag));
      icdv = hit && owner_m[int'(v.dtag)] == 0;
      dcdv = hit && owner_m[int'(v.dtag)] == 1;
      e = {ic_wins && acc, dc_wins && acc, v.rtag, cmd, addr, wdata, icdv, dcdv,
           v.mdata, v.mdata, icdv ? v.dtag : 4'd0, dcdv ? v.dtag : 4'd0};
      if (hit) owner_m.delete(int'(v.dtag));
      if (acc && cmd == 2'd1) owner_m[int'(v.rtag)] = dc_wins ? 1 : 0;
      if (ic_wins && acc) starve_m = 0;
      else if (dc_wins && v.icv && starve_m < LIMIT) starve_m++;
    end else begin
      starve_m = 0;
      owner_m.delete();
    end
    exp_q.push_back(e);
  endtask

  // driver: apply one cycle's inputs at negedge, score outputs before the next posedge
  task automatic drive_cycle(input vec_t v, input string name);
    logic [OW-1:0] a, e;
    @(negedge clock);
    reset            = v.rst;
    bus.ic_req_valid = v.icv;
    bus.ic_req_addr  = v.ica;
    bus.dc_req_cmd   = v.cmd;
    bus.dc_req_addr  = v.dca;
    bus.dc_req_data  = v.dcd;
    bus.mem_resp_tag = v.rtag;
    bus.mem_data_tag = v.dtag;
    bus.mem_data     = v.mdata;
    #1;
    model_predict(v);
    a = {bus.ic_req_accepted, bus.dc_req_accepted, bus.req_tag, bus.mem_cmd, bus.mem_addr,
         bus.mem_wdata, bus.ic_data_valid, bus.dc_data_valid, bus.ic_data, bus.dc_data,
         bus.ic_data_tag, bus.dc_data_tag};
    e = exp_q.pop_front();
    check({name, "_model"}, 256'(a), 256'(e));
  endtask

  task automatic check_vec(input vec_t v, input string name);
    check(name,
          256'({bus.ic_req_accepted, bus.dc_req_accepted, bus.mem_cmd, bus.mem_addr,
                bus.ic_data_valid, bus.dc_data_valid}),
          256'({v.e_ica, v.e_dca, v.e_cmd, v.e_addr, v.e_icdv, v.e_dcdv}));
  endtask

  vec_t tbl[16];

  initial begin
    vec_t v;
    reset = 1'b1;
    bus.ic_req_valid = 1'b0; bus.ic_req_addr = '0; bus.dc_req_cmd = '0;
    bus.dc_req_addr = '0; bus.dc_req_data = '0; bus.mem_resp_tag = '0;
    bus.mem_data = '0; bus.mem_data_tag = '0;

    //           rst icv ica          cmd dca          rt dt  ica dca cmd addr         icdv dcdv
    tbl[0]  = mk(1, 1, 32'h0000_1004, 1, 32'h0000_3008, 3, 3, 0, 0, 0, 32'h0,         0, 0);
    tbl[1]  = mk(0, 1, 32'h0000_1004, 0, 32'h0,         3, 0, 1, 0, 1, 32'h0000_1000, 0, 0);
    tbl[2]  = mk(0, 0, 32'h0,         0, 32'h0,         0, 3, 0, 0, 0, 32'h0,         1, 0);
    tbl[3]  = mk(0, 1, 32'h0000_2000, 1, 32'h0000_300B, 5, 0, 0, 1, 1, 32'h0000_3008, 0, 0);
    tbl[4]  = mk(0, 0, 32'h0,         0, 32'h0,         0, 5, 0, 0, 0, 32'h0,         0, 1);
    tbl[5]  = mk(0, 0, 32'h0,         2, 32'h0000_400F, 7, 0, 0, 1, 2, 32'h0000_4008, 0, 0);
    tbl[6]  = mk(0, 0, 32'h0,         0, 32'h0,         0, 7, 0, 0, 0, 32'h0,         0, 0);
    tbl[7]  = mk(0, 1, 32'h0000_0050, 0, 32'h0,         2, 0, 1, 0, 1, 32'h0000_0050, 0, 0);
    tbl[8]  = mk(0, 0, 32'h0,         1, 32'h0000_0060, 2, 2, 0, 1, 1, 32'h0000_0060, 1, 0);
    tbl[9]  = mk(0, 0, 32'h0,         0, 32'h0,         0, 2, 0, 0, 0, 32'h0,         0, 1);
    tbl[10] = mk(0, 1, 32'h0000_008C, 0, 32'h0,         0, 0, 0, 0, 1, 32'h0000_0088, 0, 0);
    tbl[11] = mk(0, 1, 32'h0000_0100, 0, 32'h0,         1, 0, 1, 0, 1, 32'h0000_0100, 0, 0);
    tbl[12] = mk(0, 0, 32'h0,         1, 32'h0000_0200, 4, 0, 0, 1, 1, 32'h0000_0200, 0, 0);
    tbl[13] = mk(1, 1, 32'h0000_0300, 2, 32'h0000_0400, 6, 4, 0, 0, 0, 32'h0,         0, 0);
    tbl[14] = mk(0, 0, 32'h0,         0, 32'h0,         0, 4, 0, 0, 0, 32'h0,         0, 0);
    tbl[15] = mk(0, 0, 32'h0,         0, 32'h0,         0, 1, 0, 0, 0, 32'h0,         0, 0);

    v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_cycle(v, "init_reset");
    drive_cycle(v, "init_reset");

    for (int i = 0; i < 16; i++) begin
      drive_cycle(tbl[i], $sformatf("vec%0d", i));
      check_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // starvation: dcache loads every cycle with icache pending; icache must win every 5th cycle
    for (int i = 0; i < 10; i++) begin
      logic ic_turn;
      ic_turn = (i == 4) || (i == 9);
      v = mk(0, 1, 32'h0000_0A00 + 32'(i * 8), 1, 32'h0000_0B00 + 32'(i * 8),
             4'(1 + (i % 15)), 0, ic_turn, !ic_turn, 1,
             ic_turn ? 32'h0000_0A00 + 32'(i * 8) : 32'h0000_0B00 + 32'(i * 8), 0, 0);
      drive_cycle(v, $sformatf("starve%0d", i));
      check_vec(v, $sformatf("starve%0d", i));
    end

    // starvation with rejection: icache keeps the forced grant until memory accepts it
    for (int i = 0; i < 7; i++) begin
      logic ic_turn;
      logic [3:0] rt;
      ic_turn = (i >= 4);
      rt      = (i == 4 || i == 5) ? 4'd0 : 4'd9;
      v = mk(0, 1, 32'h0000_0C00, 2, 32'h0000_0D00, rt, 0,
             ic_turn && rt != 0, !ic_turn, ic_turn ? 2'd1 : 2'd2,
             ic_turn ? 32'h0000_0C00 : 32'h0000_0D00, 0, 0);
      drive_cycle(v, $sformatf("reject%0d", i));
      check_vec(v, $sformatf("reject%0d", i));
    end
    v = mk(0, 1, 32'h0000_0C00, 1, 32'h0000_0E00, 3, 0, 0, 1, 1, 32'h0000_0E00, 0, 0);
    drive_cycle(v, "after_clear");
    check_vec(v, "after_clear");

    // random traffic scored by the model only
    for (int i = 0; i < 400; i++) begin
      v.rst   = ($urandom_range(0, 59) == 0);
      v.icv   = 1'($urandom_range(0, 1));
      v.ica   = $urandom;
      v.cmd   = 2'($urandom_range(0, 2));
      v.dca   = $urandom;
      v.dcd   = {$urandom, $urandom};
      v.rtag  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      v.dtag  = 4'($urandom_range(0, 15));
      v.mdata = {$urandom, $urandom};
      drive_cycle(v, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: NUM_TAGS, 15, usable nonzero memory tags; tag 0 means "no tag".
REQ-002 Parameter: STARVE_LIMIT, 4, consecutive lost arbitration cycles after which icache wins once.
REQ-003 Port: clock  in  1  rising-edge clock.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: ic_req_valid  in  1  icache fetch request pending.
REQ-006 Port: ic_req_addr  in  32  icache request address.
REQ-007 Port: ic_req_accepted  out  1  icache request taken by memory this cycle.
REQ-008 Port: dc_req_cmd  in  2  dcache command: 0 NONE, 1 LOAD, 2 STORE.
REQ-009 Port: dc_req_addr  in  32  dcache request address.
REQ-010 Port: dc_req_data  in  64  store data.
REQ-011 Port: dc_req_accepted  out  1  dcache request taken by memory this cycle.
REQ-012 Port: req_tag  out  4  tag assigned to the accepted request; copy of mem_resp_tag.
REQ-013 Port: mem_cmd  out  2  command to memory, same encoding as dc_req_cmd.
REQ-014 Port: mem_addr  out  32  address to memory.
REQ-015 Port: mem_wdata  out  64  store data to memory.
REQ-016 Port: mem_resp_tag  in  4  memory's tag for this cycle's command; 0 = rejected.
REQ-017 Port: mem_data  in  64  returned block.
REQ-018 Port: mem_data_tag  in  4  tag of returned block; 0 = none.
REQ-019 Port: ic_data_valid / dc_data_valid  out  1 each  returned block belongs to that requester.
REQ-020 Port: ic_data / dc_data  out  64 each  returned block, equal to mem_data.
REQ-021 Port: ic_data_tag / dc_data_tag  out  4 each  tag of the routed block.

Function
REQ-022 Grant is combinational; request, grant, mem_cmd and acceptance all occur in the same cycle.
REQ-023 Dcache has default priority when dc_req_cmd != NONE.
REQ-024 starve_cnt increments when ic_req_valid=1 and dcache is granted; it clears when icache is accepted; it saturates at STARVE_LIMIT.
REQ-025 When starve_cnt == STARVE_LIMIT and ic_req_valid=1, icache is granted regardless of the dcache command.
REQ-026 Granted icache drives mem_cmd=LOAD and mem_addr={ic_req_addr[31:3],3'b0}; granted dcache drives its cmd, aligned addr and data.
REQ-027 No grant drives mem_cmd=NONE, mem_addr=0 and mem_wdata=0.
REQ-028 The granted requester's accepted output equals (mem_resp_tag != 0); the other accepted output is 0.
REQ-029 On an accepted LOAD (either requester), owner table entry [mem_resp_tag] is set valid with owner ICACHE or DCACHE.
REQ-030 An accepted STORE creates no owner entry.
REQ-031 mem_data_tag != 0 with a valid entry asserts exactly one of ic_data_valid or dc_data_valid, per the entry's owner, in the same cycle; the entry clears at the next edge.
REQ-032 A returning tag with no valid entry is dropped: both data_valid outputs are 0.
REQ-033 If the same tag is returned and reassigned in one cycle, the return routes to the old owner and the new entry wins at the edge.
REQ-034 A rejected request (mem_resp_tag=0) does not change starve_cnt's clear condition; the requester retries.

Reset
REQ-035 Reset clears the owner table and starve_cnt; all outputs are 0 during reset and any in-flight tags are forgotten.
REQ-036 Data returning after reset for a pre-reset tag is dropped per REQ-032.

Verification
REQ-037 Icache only, addr 0x1004, mem_resp_tag=3 -> mem_cmd=LOAD, mem_addr=0x1000, ic_req_accepted=1; mem_data_tag=3 later -> ic_data_valid=1, ic_data=mem_data.
REQ-038 Both request, dcache LOAD, resp tag 5 -> dc_req_accepted=1, ic_req_accepted=0; tag 5 returns -> dc_data_valid only.
REQ-039 Dcache requests continuously with icache pending, all accepted -> the 5th cycle grants icache, then starve_cnt=0.
REQ-040 Dcache STORE accepted with tag 7; mem_data_tag=7 -> both data_valid outputs 0.
REQ-041 Tag 2 returns to icache and is re-issued to dcache in the same cycle -> ic_data_valid=1 that cycle; a later tag 2 return -> dc_data_valid=1.
REQ-042 Reset with tags 1 and 4 outstanding, then mem_data_tag=4 -> no data_valid, all outputs 0.
